// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned PAIR_W = 2 * INST_W;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_DISCARD
    } fetch_state_t;

    // Word-align a PC by clearing bits [1:0]; all bits are consumed.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: issues 64-bit aligned pair reads and writes the returned
// one or two instructions, tagged with their PCs, into the instruction FIFO.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_full,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ibus_req,
    output logic [ADDR_W-1:0] ibus_addr,
    input  logic              ibus_addr_ok,
    input  logic              ibus_data_ok,
    input  logic [PAIR_W-1:0] ibus_rdata,
    output logic              write_en1,
    output logic              write_en2,
    output logic [INST_W-1:0] write_data1,
    output logic [INST_W-1:0] write_data2,
    output logic [ADDR_W-1:0] write_address1,
    output logic [ADDR_W-1:0] write_address2
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] seq_pc;
    logic              accept;
    logic              deliver;

    assign redirect_target = word_align(redirect_pc);

    // An odd-word fetch yields only the upper instruction of the pair.
    assign seq_pc  = fetch_pc[2] ? fetch_pc + 32'd4 : fetch_pc + 32'd8;
    assign accept  = (state == FETCH_REQ) && !fifo_full && ibus_addr_ok;
    assign deliver = (state == FETCH_WAIT) && ibus_data_ok && !redirect_valid;

    // State, PC and in-flight fetch PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH_REQ;
            pc       <= word_align(RESET_PC);
            fetch_pc <= word_align(RESET_PC);
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (accept) begin
                fetch_pc <= pc;
            end
        end
    end

    // Next-state and next-PC logic.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        unique case (state)
            FETCH_REQ: begin
                if (accept) begin
                    state_next = redirect_valid ? FETCH_DISCARD : FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (ibus_data_ok) begin
                    state_next = FETCH_REQ;
                    pc_next    = seq_pc;
                end else if (redirect_valid) begin
                    state_next = FETCH_DISCARD;
                end
            end
            FETCH_DISCARD: begin
                if (ibus_data_ok) begin
                    state_next = FETCH_REQ;
                end
            end
            default: begin
                state_next = FETCH_REQ;
            end
        endcase
        // A redirect overrides any sequential PC update in every state.
        if (redirect_valid) begin
            pc_next = redirect_target;
        end
    end

    // Bus request and FIFO write outputs.
    always_comb begin
        ibus_req       = 1'b0;
        ibus_addr      = {pc[ADDR_W-1:3], 3'b000};
        write_en1      = 1'b0;
        write_en2      = 1'b0;
        write_data1    = '0;
        write_data2    = '0;
        write_address1 = '0;
        write_address2 = '0;
        if (state == FETCH_REQ) begin
            ibus_req = !fifo_full;
        end
        if (deliver) begin
            write_en1      = 1'b1;
            write_address1 = fetch_pc;
            if (fetch_pc[2]) begin
                write_data1 = ibus_rdata[PAIR_W-1:INST_W];
            end else begin
                write_data1    = ibus_rdata[INST_W-1:0];
                write_en2      = 1'b1;
                write_data2    = ibus_rdata[PAIR_W-1:INST_W];
                write_address2 = fetch_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        fifo_full;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_addr_ok;
    logic        ibus_data_ok;
    logic [63:0] ibus_rdata;
    logic        write_en1;
    logic        write_en2;
    logic [31:0] write_data1;
    logic [31:0] write_data2;
    logic [31:0] write_address1;
    logic [31:0] write_address2;

    int checks;
    int failures;

    instruction_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_full      (fifo_full),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ibus_req       (ibus_req),
        .ibus_addr      (ibus_addr),
        .ibus_addr_ok   (ibus_addr_ok),
        .ibus_data_ok   (ibus_data_ok),
        .ibus_rdata     (ibus_rdata),
        .write_en1      (write_en1),
        .write_en2      (write_en2),
        .write_data1    (write_data1),
        .write_data2    (write_data2),
        .write_address1 (write_address1),
        .write_address2 (write_address2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fifo_full      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ibus_addr_ok   = 1'b0;
        ibus_data_ok   = 1'b0;
        ibus_rdata     = 64'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ibus_req !== 1'b1) begin
            failures++; $display("FAIL reset_req got=%0h exp=1", ibus_req);
        end
        checks++;
        if (ibus_addr !== 32'hBFC0_0000) begin
            failures++; $display("FAIL reset_addr got=%08h exp=bfc00000", ibus_addr);
        end
        checks++;
        if ({write_en1, write_en2, write_data1, write_data2, write_address1, write_address2} !== '0) begin
            failures++; $display("FAIL reset_writes en1=%0h en2=%0h d1=%08h a1=%08h", write_en1, write_en2, write_data1, write_address1);
        end
    endtask

    task automatic test_zero_wait();
        ibus_addr_ok = 1'b1;
        tick();
        ibus_addr_ok = 1'b0;
        ibus_data_ok = 1'b1;
        ibus_rdata   = {32'h2222_2222, 32'h1111_1111};
        #1;
        checks++;
        if (ibus_req !== 1'b0) begin
            failures++; $display("FAIL zw_req_in_wait got=%0h exp=0", ibus_req);
        end
        checks++;
        if (write_en1 !== 1'b1 || write_en2 !== 1'b1) begin
            failures++; $display("FAIL zw_enables got=%0h%0h exp=11", write_en1, write_en2);
        end
        checks++;
        if (write_data1 !== 32'h1111_1111 || write_address1 !== 32'hBFC0_0000) begin
            failures++; $display("FAIL zw_slot1 got=%08h@%08h exp=11111111@bfc00000", write_data1, write_address1);
        end
        checks++;
        if (write_data2 !== 32'h2222_2222 || write_address2 !== 32'hBFC0_0004) begin
            failures++; $display("FAIL zw_slot2 got=%08h@%08h exp=22222222@bfc00004", write_data2, write_address2);
        end
        tick();
        ibus_data_ok = 1'b0;
        #1;
        checks++;
        if (ibus_req !== 1'b1 || ibus_addr !== 32'hBFC0_0008) begin
            failures++; $display("FAIL zw_next got req=%0h addr=%08h exp req=1 addr=bfc00008", ibus_req, ibus_addr);
        end
    endtask

    task automatic test_redirect_odd();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0014;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ibus_req !== 1'b1 || ibus_addr !== 32'h8000_0010) begin
            failures++; $display("FAIL odd_addr got req=%0h addr=%08h exp req=1 addr=80000010", ibus_req, ibus_addr);
        end
        ibus_addr_ok = 1'b1;
        tick();
        ibus_addr_ok = 1'b0;
        ibus_data_ok = 1'b1;
        ibus_rdata   = {32'hAAAA_AAAA, 32'hBBBB_BBBB};
        #1;
        checks++;
        if (write_en1 !== 1'b1 || write_en2 !== 1'b0) begin
            failures++; $display("FAIL odd_enables got=%0h%0h exp=10", write_en1, write_en2);
        end
        checks++;
        if (write_data1 !== 32'hAAAA_AAAA || write_address1 !== 32'h8000_0014) begin
            failures++; $display("FAIL odd_slot1 got=%08h@%08h exp=aaaaaaaa@80000014", write_data1, write_address1);
        end
        checks++;
        if (write_data2 !== 32'h0 || write_address2 !== 32'h0) begin
            failures++; $display("FAIL odd_slot2_zero got=%08h@%08h exp=0@0", write_data2, write_address2);
        end
        tick();
        ibus_data_ok = 1'b0;
        #1;
        checks++;
        if (ibus_addr !== 32'h8000_0018) begin
            failures++; $display("FAIL odd_next got=%08h exp=80000018", ibus_addr);
        end
    endtask

    task automatic test_redirect_in_wait();
        ibus_addr_ok = 1'b1;
        tick();
        ibus_addr_ok   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        #1;
        checks++;
        if (write_en1 !== 1'b0) begin
            failures++; $display("FAIL wait_redir_nowrite got=%0h exp=0", write_en1);
        end
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (ibus_req !== 1'b0) begin
                failures++; $display("FAIL discard_req cycle=%0d got=%0h exp=0", i, ibus_req);
            end
            tick();
        end
        ibus_data_ok = 1'b1;
        ibus_rdata   = {32'hDEAD_BEEF, 32'hCAFE_F00D};
        #1;
        checks++;
        if (write_en1 !== 1'b0 || write_en2 !== 1'b0 || write_data1 !== 32'h0) begin
            failures++; $display("FAIL discard_drop got en1=%0h en2=%0h d1=%08h exp 0", write_en1, write_en2, write_data1);
        end
        tick();
        ibus_data_ok = 1'b0;
        #1;
        checks++;
        if (ibus_req !== 1'b1 || ibus_addr !== 32'h8000_0100) begin
            failures++; $display("FAIL discard_next got req=%0h addr=%08h exp req=1 addr=80000100", ibus_req, ibus_addr);
        end
    endtask

    task automatic test_redirect_with_data();
        ibus_addr_ok = 1'b1;
        tick();
        ibus_addr_ok   = 1'b0;
        ibus_data_ok   = 1'b1;
        ibus_rdata     = {32'h3333_3333, 32'h4444_4444};
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1234_567B;
        #1;
        checks++;
        if (write_en1 !== 1'b0 || write_en2 !== 1'b0) begin
            failures++; $display("FAIL redir_data_nowrite got=%0h%0h exp=00", write_en1, write_en2);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ibus_req !== 1'b1 || ibus_addr !== 32'h1234_5678) begin
            failures++; $display("FAIL redir_data_next got req=%0h addr=%08h exp req=1 addr=12345678", ibus_req, ibus_addr);
        end
        ibus_addr_ok = 1'b1;
        tick();
        ibus_addr_ok = 1'b0;
        ibus_data_ok = 1'b1;
        ibus_rdata   = {32'h5555_5555, 32'h6666_6666};
        #1;
        checks++;
        if (write_en2 !== 1'b1 || write_address1 !== 32'h1234_5678 || write_address2 !== 32'h1234_567C) begin
            failures++; $display("FAIL redir_masked got en2=%0h a1=%08h a2=%08h exp en2=1 a1=12345678 a2=1234567c", write_en2, write_address1, write_address2);
        end
        tick();
        ibus_data_ok = 1'b0;
    endtask

    task automatic test_redirect_on_accept();
        ibus_addr_ok   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ibus_req !== 1'b0) begin
            failures++; $display("FAIL accept_redir_discard got req=%0h exp=0", ibus_req);
        end
        ibus_data_ok = 1'b1;
        ibus_rdata   = {32'h7777_7777, 32'h8888_8888};
        #1;
        checks++;
        if (write_en1 !== 1'b0) begin
            failures++; $display("FAIL accept_redir_drop got=%0h exp=0", write_en1);
        end
        tick();
        ibus_data_ok = 1'b0;
        #1;
        checks++;
        if (ibus_req !== 1'b1 || ibus_addr !== 32'h8000_0300) begin
            failures++; $display("FAIL accept_redir_next got req=%0h addr=%08h exp req=1 addr=80000300", ibus_req, ibus_addr);
        end
    endtask

    task automatic test_fifo_full();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ibus_req !== 1'b0 || ibus_addr !== 32'h8000_0300) begin
                failures++; $display("FAIL full_hold cycle=%0d got req=%0h addr=%08h exp req=0 addr=80000300", i, ibus_req, ibus_addr);
            end
            tick();
        end
        fifo_full = 1'b0;
        #1;
        checks++;
        if (ibus_req !== 1'b1 || ibus_addr !== 32'h8000_0300) begin
            failures++; $display("FAIL full_release got req=%0h addr=%08h exp req=1 addr=80000300", ibus_req, ibus_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        idle_inputs();
        ibus_addr_ok = 1'b1;
        tick();
        ibus_addr_ok = 1'b0;
        ibus_data_ok = 1'b1;
        ibus_rdata   = {32'h9999_9999, 32'h0000_1234};
        #1;
        checks++;
        if (write_en2 !== 1'b1 || write_address1 !== 32'hFFFF_FFF8 || write_address2 !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_addrs got en2=%0h a1=%08h a2=%08h exp en2=1 a1=fffffff8 a2=fffffffc", write_en2, write_address1, write_address2);
        end
        tick();
        ibus_data_ok = 1'b0;
        #1;
        checks++;
        if (ibus_addr !== 32'h0000_0000) begin
            failures++; $display("FAIL wrap_next got=%08h exp=00000000", ibus_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        ibus_addr_ok = 1'b1;
        tick();
        ibus_addr_ok = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ibus_req !== 1'b1 || ibus_addr !== 32'hBFC0_0000) begin
            failures++; $display("FAIL rst_wait_req got req=%0h addr=%08h exp req=1 addr=bfc00000", ibus_req, ibus_addr);
        end
        checks++;
        if (write_en1 !== 1'b0) begin
            failures++; $display("FAIL rst_wait_nowrite got=%0h exp=0", write_en1);
        end
        // A stray data_ok while requesting must never produce a FIFO write.
        ibus_data_ok = 1'b1;
        ibus_rdata   = {32'hFEED_FACE, 32'hBAAD_C0DE};
        #1;
        checks++;
        if (write_en1 !== 1'b0 || write_en2 !== 1'b0) begin
            failures++; $display("FAIL req_stray_data got=%0h%0h exp=00", write_en1, write_en2);
        end
        tick();
        ibus_data_ok = 1'b0;
        #1;
        checks++;
        if (ibus_req !== 1'b1 || ibus_addr !== 32'hBFC0_0000) begin
            failures++; $display("FAIL req_stray_hold got req=%0h addr=%08h exp req=1 addr=bfc00000", ibus_req, ibus_addr);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_zero_wait();
        test_redirect_odd();
        test_redirect_in_wait();
        test_redirect_with_data();
        test_redirect_on_accept();
        test_fifo_full();
        test_wrap();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that sits directly upstream of the instruction FIFO. It holds the fetch PC, issues 64-bit aligned instruction-pair reads on the instruction bus, and writes the returned one or two instructions, tagged with their addresses, into the FIFO write port. It applies backpressure from FIFO `full`, and handles branch/exception redirects, including discarding a response already in flight.

## Interface
- `RESET_PC`, default `32'hBFC0_0000`: PC loaded on reset; bits [1:0] must be 0.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `fifo_full` in 1: FIFO `full`; asserted when FIFO count ≥ 14.
- `redirect_valid` in 1: load a new PC this cycle (branch resolve or exception).
- `redirect_pc` in 32: target PC; bits [1:0] are ignored and forced to 0.
- `ibus_req` out 1: read request.
- `ibus_addr` out 32: pair address, always `{pc[31:3],3'b000}`.
- `ibus_addr_ok` in 1: request accepted this cycle.
- `ibus_data_ok` in 1: read data valid this cycle.
- `ibus_rdata` in 64: [31:0] = word at `addr`, [63:32] = word at `addr+4`.
- `write_en1`, `write_en2` out 1 each: FIFO write enables. `write_en2` implies `write_en1`.
- `write_data1`, `write_data2` out 32 each: instructions.
- `write_address1`, `write_address2` out 32 each: their PCs.

## Operation
- State machine with three states:
  - REQ: requesting.
  - WAIT: request accepted, awaiting data.
  - DISCARD: accepted request is stale; drop its data.
- At most one request is outstanding at any time.
- REQ:
  - `ibus_req = !fifo_full`.
  - `ibus_req && ibus_addr_ok` → WAIT; `pc` is latched as `fetch_pc`.
  - If `redirect_valid` in the same cycle as acceptance → DISCARD, with `pc <= redirect_pc`.
  - If `redirect_valid` with no acceptance → stay in REQ, `pc <= redirect_pc`. The bus tolerates an address change while a request is unaccepted.
- WAIT:
  - `ibus_req = 0`.
  - On `ibus_data_ok` with no redirect → write to the FIFO (rules below) → REQ, `pc <= next_pc`.
  - `redirect_valid` without `data_ok` → DISCARD, `pc <= redirect_pc`.
  - `redirect_valid` together with `data_ok` → no write → REQ, `pc <= redirect_pc`.
- DISCARD:
  - `ibus_req = 0`.
  - `ibus_data_ok` → no write → REQ.
  - `redirect_valid` updates `pc` in any cycle; the state is unaffected except by `data_ok`.
- FIFO write rules. Writes are combinational in the `data_ok` cycle, only in WAIT, and never in REQ or DISCARD.
  - `fetch_pc[2]==0`: `write_en1 = write_en2 = 1`.
    - data1 = `rdata[31:0]`, address1 = `fetch_pc`.
    - data2 = `rdata[63:32]`, address2 = `fetch_pc+4`.
    - `next_pc = fetch_pc+8`.
  - `fetch_pc[2]==1`: `write_en1 = 1`, `write_en2 = 0`.
    - data1 = `rdata[63:32]`, address1 = `fetch_pc`.
    - `next_pc = fetch_pc+4`.
  - When a write enable is low, its data and address outputs are 0.
- Arithmetic is 32-bit modulo; `pc` wraps from `32'hFFFF_FFF8` to 0 with no flag.
- Backpressure: a request is issued only while `!fifo_full` (count ≤ 13). With one request outstanding, at most 2 entries arrive, so the FIFO (16 entries) never overflows.
- `fifo_full` is never sampled in WAIT or DISCARD; data is always accepted.
- Reset, including mid-transaction: `state <= REQ`, `pc <= RESET_PC`.
  - An in-flight bus response is **not** tracked across reset. The bus is reset with the same `rst`.

## Timing
- Reset values (cycle after `rst`):
  - `ibus_req = 1` (if `!fifo_full`), `ibus_addr = RESET_PC & ~7`.
  - All `write_*` outputs = 0.
- Fetch latency: FIFO write in the same cycle as `ibus_data_ok`.
- Minimum turnaround: the next `ibus_req` is asserted in the cycle after `data_ok`.
- Zero-wait bus: one pair per 2 cycles.
- `redirect_valid` is sampled every cycle; the new PC appears on `ibus_addr` the next cycle when the state is REQ.
- All outputs are functions of registered state plus same-cycle `fifo_full`, `ibus_data_ok`, `redirect_valid` and `ibus_rdata`. There are no combinational paths from `ibus_addr_ok` to outputs.

## Structure
- Shared package `fetch_pkg`:
  - `typedef enum logic [1:0] {FETCH_REQ, FETCH_WAIT, FETCH_DISCARD} fetch_state_t`.
  - Constant `RESET_PC_DEFAULT = 32'hBFC0_0000`.
- Single module; no sub-module is needed. The PC/next-PC logic is kept inline.

## Test plan
- Reset, then a zero-wait bus returning `{32'h2222_2222, 32'h1111_1111}`:
  - First write: en1 = en2 = 1; data1 = `1111_1111` @ `BFC0_0000`, data2 = `2222_2222` @ `BFC0_0004`.
  - Next `ibus_addr` = `BFC0_0008`.
- Redirect to `32'h8000_0014`:
  - `ibus_addr` = `8000_0010`.
  - Write en1 only: data1 = `rdata[63:32]` @ `8000_0014`; next addr = `8000_0018`.
- Redirect to `32'h8000_0100` in WAIT, with `data_ok` 3 cycles later:
  - No write; the next request is at `8000_0100`.
- Redirect in the same cycle as `data_ok`:
  - No write; the next request uses the redirect PC.
- `fifo_full` held high for 5 cycles while in REQ:
  - `ibus_req` stays low for those 5 cycles and rises the cycle `full` drops.
  - The address is unchanged.
- Assert `rst` in WAIT:
  - Next cycle: REQ at `RESET_PC`, no write.
  - The late `data_ok` from the killed request is ignored by the reset bus model.
